// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register family (piso / sipo members).
//   shift_state_e : framing state, ST_IDLE = no word, ST_SHIFT = word in flight
//   clog2()       : counter width helper, never returns less than 1
package shift_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_e;

    // ceil(log2(n)) with a floor of 1 so a WIDTH==1 word still has a 1-bit index.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bit_index_counter.sv
// Mod-WIDTH up counter giving the index of the bit currently on the serial line.
//   clk  in        clock, posedge
//   rst  in        asynchronous active-low reset
//   clr  in        synchronous clear to 0 (wins over en)
//   en   in        advance by one, wrapping WIDTH-1 -> 0
//   cnt  out [CW]  current index, 0..WIDTH-1
//   tc   out       terminal count (cnt == WIDTH-1)
module bit_index_counter
    import shift_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CW    = clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc  = (cnt_q == CW'(WIDTH - 1));
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in / serial-out transmitter with first/last frame markers.
//   clk       in          clock, posedge
//   rst       in          asynchronous active-low reset
//   pdata     in  [WIDTH] parallel word, sampled on accept only
//   pvalid    in          pdata valid
//   pready    out         word can be accepted this cycle (combinational)
//   shift_en  in          downstream consumes the current serial bit at this edge
//   sdata     out         serial bit (straight from the shift register flop)
//   svalid    out         sdata holds a valid bit
//   sfirst    out         current bit is the first of its word
//   slast     out         current bit is the last of its word
//   busy      out         word in flight (same as svalid)
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no word held; pready high, shift_en ignored
// ST_SHIFT | word in shreg, cnt = index of bit on sdata; reload allowed
//          | in the slast cycle when shift_en is high (gapless frames)
module piso_shift_tx
    import shift_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pdata,
    input  logic             pvalid,
    output logic             pready,
    input  logic             shift_en,
    output logic             sdata,
    output logic             svalid,
    output logic             sfirst,
    output logic             slast,
    output logic             busy
);

    localparam int CW = clog2(WIDTH);

    shift_state_e   state_q;
    shift_state_e   state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]  cnt;
    logic           cnt_tc;
    logic           cnt_clr;
    logic           cnt_en;
    logic           accept;
    logic           in_shift;

    bit_index_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_index_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    assign in_shift = (state_q == ST_SHIFT);
    assign svalid   = in_shift;
    assign busy     = in_shift;
    assign sfirst   = in_shift && (cnt == '0);
    assign slast    = in_shift && cnt_tc;
    // rst gates pready so nothing upstream sees a handshake while held in reset.
    assign pready   = rst && (!in_shift || (slast && shift_en));
    assign accept   = pvalid && pready;
    assign sdata    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (accept) begin
            state_d = ST_SHIFT;
            shreg_d = pdata;
            cnt_clr = 1'b1;
        end else if (in_shift && shift_en) begin
            // The last shift also zero-fills, so the line idles at 0.
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            cnt_en  = 1'b1;
            if (cnt_tc) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
module tb_piso_shift_tx;

    logic       clk;
    logic       rst;

    logic [2:0] pdata;
    logic       pvalid, shift_en;
    logic       pready, sdata, svalid, sfirst, slast, busy;

    logic [2:0] pdata_b;
    logic       pvalid_b, shift_en_b;
    logic       pready_b, sdata_b, svalid_b, sfirst_b, slast_b, busy_b;

    logic [0:0] pdata_c;
    logic       pvalid_c, shift_en_c;
    logic       pready_c, sdata_c, svalid_c, sfirst_c, slast_c, busy_c;

    int n_checks = 0;
    int n_pass   = 0;

    piso_shift_tx #(.WIDTH(3), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .pdata(pdata), .pvalid(pvalid), .pready(pready),
        .shift_en(shift_en), .sdata(sdata), .svalid(svalid), .sfirst(sfirst),
        .slast(slast), .busy(busy)
    );

    piso_shift_tx #(.WIDTH(3), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .pdata(pdata_b), .pvalid(pvalid_b), .pready(pready_b),
        .shift_en(shift_en_b), .sdata(sdata_b), .svalid(svalid_b), .sfirst(sfirst_b),
        .slast(slast_b), .busy(busy_b)
    );

    piso_shift_tx #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_w1 (
        .clk(clk), .rst(rst), .pdata(pdata_c), .pvalid(pvalid_c), .pready(pready_c),
        .shift_en(shift_en_c), .sdata(sdata_c), .svalid(svalid_c), .sfirst(sfirst_c),
        .slast(slast_c), .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vectors below are {svalid, sdata, sfirst, slast}.

    task automatic test_reset();
        pdata = 3'b000; pvalid = 1'b0; shift_en = 1'b0;
        rst = 1'b0;
        #3;
        n_checks++;
        if ({svalid, sdata, sfirst, slast, busy} !== 5'b00000)
            $display("FAIL reset_outputs: got %b want 00000", {svalid, sdata, sfirst, slast, busy});
        else n_pass++;
        n_checks++;
        if (pready !== 1'b0) $display("FAIL reset_pready: got %b want 0", pready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (pready !== 1'b1) $display("FAIL release_pready: got %b want 1", pready);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [3:0] exp_o [5] = '{4'b0000, 4'b1110, 4'b1000, 4'b1101, 4'b0000};
        logic       exp_r [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            pdata = 3'b101; shift_en = 1'b1;
            pvalid = (i == 0);
            #1;
            n_checks++;
            if ({svalid, sdata, sfirst, slast} !== exp_o[i])
                $display("FAIL single_out[%0d]: got %b want %b", i, {svalid, sdata, sfirst, slast}, exp_o[i]);
            else n_pass++;
            n_checks++;
            if (busy !== exp_o[i][3]) $display("FAIL single_busy[%0d]: got %b want %b", i, busy, exp_o[i][3]);
            else n_pass++;
            n_checks++;
            if (pready !== exp_r[i]) $display("FAIL single_pready[%0d]: got %b want %b", i, pready, exp_r[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_o [7] = '{4'b0000, 4'b1110, 4'b1100, 4'b1001, 4'b1010, 4'b1100, 4'b1101};
        logic       exp_r [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        shift_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pdata  = (i == 0) ? 3'b110 : 3'b011;
            pvalid = (i < 4);
            #1;
            if (i < 7) begin
                n_checks++;
                if ({svalid, sdata, sfirst, slast} !== exp_o[i])
                    $display("FAIL b2b_out[%0d]: got %b want %b", i, {svalid, sdata, sfirst, slast}, exp_o[i]);
                else n_pass++;
                n_checks++;
                if (pready !== exp_r[i]) $display("FAIL b2b_pready[%0d]: got %b want %b", i, pready, exp_r[i]);
                else n_pass++;
            end else begin
                n_checks++;
                if ({svalid, sdata, busy} !== 3'b000)
                    $display("FAIL b2b_idle: got %b want 000", {svalid, sdata, busy});
                else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic [3:0] exp_o [7] = '{4'b0000, 4'b1110, 4'b1110, 4'b1110, 4'b1000, 4'b1001, 4'b0000};
        logic       exp_r [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       se    [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            shift_en = se[i];
            // pvalid raised while pready is low with a different word: must be ignored.
            pdata  = (i == 0) ? 3'b100 : 3'b011;
            pvalid = (i == 0) || (i == 2) || (i == 3);
            #1;
            n_checks++;
            if ({svalid, sdata, sfirst, slast} !== exp_o[i])
                $display("FAIL stall_out[%0d]: got %b want %b", i, {svalid, sdata, sfirst, slast}, exp_o[i]);
            else n_pass++;
            n_checks++;
            if (pready !== exp_r[i]) $display("FAIL stall_pready[%0d]: got %b want %b", i, pready, exp_r[i]);
            else n_pass++;
            @(negedge clk);
        end
        pvalid = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        shift_en = 1'b1;
        pdata = 3'b111; pvalid = 1'b1;
        @(negedge clk);
        pvalid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({svalid, sdata, sfirst, slast} !== 4'b1100)
            $display("FAIL midrst_pre: got %b want 1100", {svalid, sdata, sfirst, slast});
        else n_pass++;
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({svalid, sdata, sfirst, slast, busy, pready} !== 6'b000000)
            $display("FAIL midrst_outputs: got %b want 000000", {svalid, sdata, sfirst, slast, busy, pready});
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if ({svalid, sdata} !== 2'b00)
                $display("FAIL midrst_residual[%0d]: got %b want 00", i, {svalid, sdata});
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_variants();
        logic [3:0] exp_b [5] = '{4'b0000, 4'b1010, 4'b1100, 4'b1101, 4'b0000};
        logic       rdy_b [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] exp_c [3] = '{4'b0000, 4'b1111, 4'b0000};
        shift_en_b = 1'b1; shift_en_c = 1'b1;
        pdata_b = 3'b110; pdata_c = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pvalid_b = (i == 0);
            pvalid_c = (i == 0);
            #1;
            n_checks++;
            if ({svalid_b, sdata_b, sfirst_b, slast_b} !== exp_b[i])
                $display("FAIL lsb_out[%0d]: got %b want %b", i, {svalid_b, sdata_b, sfirst_b, slast_b}, exp_b[i]);
            else n_pass++;
            n_checks++;
            if (pready_b !== rdy_b[i]) $display("FAIL lsb_pready[%0d]: got %b want %b", i, pready_b, rdy_b[i]);
            else n_pass++;
            if (i < 3) begin
                n_checks++;
                if ({svalid_c, sdata_c, sfirst_c, slast_c} !== exp_c[i])
                    $display("FAIL w1_out[%0d]: got %b want %b", i, {svalid_c, sdata_c, sfirst_c, slast_c}, exp_c[i]);
                else n_pass++;
                n_checks++;
                if (pready_c !== 1'b1) $display("FAIL w1_pready[%0d]: got %b want 1", i, pready_c);
                else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        pdata_b = '0; pvalid_b = 1'b0; shift_en_b = 1'b0;
        pdata_c = '0; pvalid_c = 1'b0; shift_en_c = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        test_variants();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
